// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: frame FSM encoding, frame geometry, parity helper.
package ps2_pkg;
  localparam int PS2_DATA_BITS = 8;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e;

  // Registered one-cycle event bundle driven out of the receiver.
  typedef struct packed {
    logic ready;
    logic parity;
    logic frame;
    logic ovf;
  } rx_evt_t;

  // True when data plus parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] d, input logic p);
    return ^{d, p};
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Show-ahead register-array FIFO with a registered head output; a push into a full
// FIFO succeeds only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [AW:0]                 cnt_nxt;
  logic [WIDTH-1:0]            head_nxt;
  logic                        do_push, do_pop;

  assign empty      = (count == '0);
  assign full       = (count == (AW+1)'(DEPTH));
  assign do_pop     = rd_en & ~empty;
  assign do_push    = wr_en & (~full | do_pop);
  assign cnt_nxt    = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign rd_ptr_nxt = rd_ptr + AW'(do_pop);
  // The written slot can only be the next head when the FIFO holds one entry afterwards.
  assign head_nxt   = (do_push && wr_ptr == rd_ptr_nxt) ? wr_data : mem[rd_ptr_nxt];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      wr_ptr   <= wr_ptr + AW'(do_push);
      rd_ptr   <= rd_ptr_nxt;
      count    <= cnt_nxt;
      rd_valid <= (cnt_nxt != '0);
      rd_data  <= (cnt_nxt != '0) ? head_nxt : '0;
    end
  end
endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronise + deglitch both lines, decode 11-bit frames on
// falling kbd_clk, recover from truncated frames, and buffer scan codes in a FIFO.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH   = 8,
  parameter int FILTER_LEN   = 4,
  parameter int TIMEOUT_CYC  = 50000,
  parameter int PARITY_CHECK = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          kbd_clk,
  input  logic                          kbd_data,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          ready_pulse,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  localparam int BW = $clog2(PS2_DATA_BITS);

  // Line 0 is kbd_clk, line 1 is kbd_data.
  logic [1:0]          raw, filt;
  logic [1:0][1:0]     sync_q;
  logic [1:0][FW-1:0]  flt_cnt;
  logic                kc_prev, fall, kd;

  assign raw = {kbd_data, kbd_clk};

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q  <= '1;
      filt    <= '1;
      flt_cnt <= '0;
      kc_prev <= 1'b1;
    end else begin
      kc_prev <= filt[0];
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= {sync_q[i][0], raw[i]};
        if (sync_q[i][1] != filt[i]) begin
          if (flt_cnt[i] == FW'(FILTER_LEN - 1)) begin
            filt[i]    <= sync_q[i][1];
            flt_cnt[i] <= '0;
          end else begin
            flt_cnt[i] <= flt_cnt[i] + FW'(1);
          end
        end else begin
          flt_cnt[i] <= '0;
        end
      end
    end
  end

  assign fall = kc_prev & ~filt[0];
  assign kd   = filt[1];

  ps2_state_e               state, state_nxt;
  logic [BW-1:0]            bit_cnt, bit_nxt;
  logic [PS2_DATA_BITS-1:0] shreg, sh_nxt;
  logic                     par_bit, par_nxt, par_ok;
  logic [WW-1:0]            wd_cnt, wd_nxt;
  logic                     push, perr, ferr, accept;
  logic                     fifo_full, fifo_empty;
  rx_evt_t                  evt;

  assign par_ok = odd_parity_ok(shreg, par_bit);

  always_comb begin
    state_nxt = state;
    bit_nxt   = bit_cnt;
    sh_nxt    = shreg;
    par_nxt   = par_bit;
    wd_nxt    = (state == IDLE || fall) ? '0 : wd_cnt + WW'(1);
    push      = 1'b0;
    perr      = 1'b0;
    ferr      = 1'b0;
    if (state != IDLE && wd_cnt == WW'(TIMEOUT_CYC)) begin
      state_nxt = IDLE;
      wd_nxt    = '0;
      ferr      = 1'b1;
    end else if (fall) begin
      case (state)
        IDLE: if (!kd) begin
          state_nxt = DATA;
          bit_nxt   = '0;
        end
        DATA: begin
          sh_nxt  = {kd, shreg[PS2_DATA_BITS-1:1]};
          bit_nxt = bit_cnt + BW'(1);
          if (bit_cnt == BW'(PS2_DATA_BITS - 1)) state_nxt = PARITY;
        end
        PARITY: begin
          par_nxt   = kd;
          state_nxt = STOP;
        end
        STOP: begin
          push      = kd & (par_ok | (PARITY_CHECK == 0));
          ferr      = ~kd;
          perr      = ~par_ok;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Mirrors the FIFO acceptance rule so a drop can be reported as overflow.
  assign accept = push & (~fifo_full | (rd_en & ~fifo_empty));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      wd_cnt  <= '0;
      evt     <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_nxt;
      shreg   <= sh_nxt;
      par_bit <= par_nxt;
      wd_cnt  <= wd_nxt;
      evt     <= '{ready: accept, parity: perr, frame: ferr, ovf: push & ~accept};
    end
  end

  assign ready_pulse = evt.ready;
  assign parity_err  = evt.parity;
  assign frame_err   = evt.frame;
  assign overflow    = evt.ovf;

  sync_fifo #(.WIDTH(PS2_DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (push),
    .wr_data  (sh_nxt),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .count    (count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );
endmodule
